// File: rtl/inst_rom_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// inst_rom_arbiter_pkg
// Shared constants and types for the instruction-ROM read-port arbiter:
//   ZERO_WORD / CHIP_ENABLE / CHIP_DISABLE : bus idle values
//   INST_MEM_NUM      : number of 32-bit words in inst_rom
//   ROM_ARB_MAX_WAIT  : default starvation limit (cycles a loser may wait)
//   rom_owner_e       : identity of the port that last won the ROM
//   rom_addr_bad()    : misaligned / out-of-range byte address check
// -----------------------------------------------------------------------------
package inst_rom_arbiter_pkg;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;

    localparam int unsigned INST_MEM_NUM     = 1024;
    localparam int unsigned ROM_ARB_MAX_WAIT = 4;

    typedef enum logic {
        ROM_OWNER_IF  = 1'b0,
        ROM_OWNER_MEM = 1'b1
    } rom_owner_e;

    // A word fetch must be 4-byte aligned and lie inside the ROM.
    function automatic logic rom_addr_bad(input logic [31:0] addr,
                                          input logic [31:0] rom_bytes);
        return (addr[1:0] != 2'b00) || (addr >= rom_bytes);
    endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// -----------------------------------------------------------------------------
// rom_arb_pick
// Combinational winner select for the shared ROM read port.
//   if_req_i / mem_req_i   : pending requests
//   if_sat_i / mem_sat_i   : requester has waited MAX_WAIT cycles
//   last_owner_i           : previous winner (only with ROM_ARB_FAIR_EN)
//   if_gnt_o / mem_gnt_o   : one-hot grant (or none when idle)
// Tie policy: ROM_ARB_FAIR_EN defined -> round-robin on last_owner_i,
//             undefined -> MEM has priority over IF.
// -----------------------------------------------------------------------------
module rom_arb_pick
    import inst_rom_arbiter_pkg::*;
(
    input  logic if_req_i,
    input  logic mem_req_i,
    input  logic if_sat_i,
    input  logic mem_sat_i,
`ifdef ROM_ARB_FAIR_EN
    input  logic last_owner_i,
`endif
    output logic if_gnt_o,
    output logic mem_gnt_o
);

    always_comb begin
        if_gnt_o  = 1'b0;
        mem_gnt_o = 1'b0;
        if (if_req_i && mem_req_i) begin
            // A starved requester overrides the tie policy; if both are
            // somehow saturated the normal policy decides.
            if (if_sat_i && !mem_sat_i) begin
                if_gnt_o = 1'b1;
            end else if (mem_sat_i && !if_sat_i) begin
                mem_gnt_o = 1'b1;
            end else begin
`ifdef ROM_ARB_FAIR_EN
                if (last_owner_i == ROM_OWNER_MEM) begin
                    if_gnt_o = 1'b1;
                end else begin
                    mem_gnt_o = 1'b1;
                end
`else
                // Drain the load stall first.
                mem_gnt_o = 1'b1;
`endif
            end
        end else begin
            if_gnt_o  = if_req_i;
            mem_gnt_o = mem_req_i;
        end
    end

endmodule

// File: rtl/inst_rom_arbiter.sv
// -----------------------------------------------------------------------------
// inst_rom_arbiter
// Shares the single combinational read port of inst_rom between the IF-stage
// fetch port and the MEM-stage constant-load port. One grant per cycle, the
// ROM data is captured into a response register (1-cycle read latency).
// Optional macro: ROM_ARB_FAIR_EN (round-robin ties; default MEM-priority).
// Ports:
//   clk, rst (async, active-low)
//   if_req/if_addr/if_flush  -> if_gnt (comb), if_rvalid/if_inst (registered)
//   mem_req/mem_addr         -> mem_gnt (comb), mem_rvalid/mem_rdata (registered)
//   rsp_err                  : registered, response in flight had a bad address
//   rom_ce/rom_addr -> inst_rom, rom_inst <- inst_rom (same cycle)
// -----------------------------------------------------------------------------
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = ROM_ARB_MAX_WAIT,
    parameter int unsigned ROM_BYTES = INST_MEM_NUM * 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_inst,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        rsp_err,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst
);

    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
    localparam logic [31:0]       ROM_BYTES_C = 32'(ROM_BYTES);

    // Port index 0 = IF, 1 = MEM.
    logic [1:0] req_vec;
    logic [1:0] gnt_vec;
    logic [1:0] sat_vec;

    assign req_vec = {mem_req, if_req};
    assign gnt_vec = {mem_gnt, if_gnt};

    // Per-port starvation counters.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wait
            logic [WAIT_W-1:0] wait_q;
            logic [WAIT_W-1:0] wait_d;

            always_comb begin
                wait_d = '0;
                if (req_vec[gi] && !gnt_vec[gi]) begin
                    wait_d = (wait_q == MAX_WAIT_C) ? wait_q : wait_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wait_q <= '0;
                end else begin
                    wait_q <= wait_d;
                end
            end

            assign sat_vec[gi] = (wait_q == MAX_WAIT_C);
        end
    endgenerate

`ifdef ROM_ARB_FAIR_EN
    rom_owner_e last_owner_q;

    // Reset to MEM so the first tie goes to IF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= ROM_OWNER_MEM;
        end else if (if_gnt) begin
            last_owner_q <= ROM_OWNER_IF;
        end else if (mem_gnt) begin
            last_owner_q <= ROM_OWNER_MEM;
        end
    end
`endif

    rom_arb_pick u_pick (
        .if_req_i     (if_req),
        .mem_req_i    (mem_req),
        .if_sat_i     (sat_vec[0]),
        .mem_sat_i    (sat_vec[1]),
`ifdef ROM_ARB_FAIR_EN
        .last_owner_i (last_owner_q),
`endif
        .if_gnt_o     (if_gnt),
        .mem_gnt_o    (mem_gnt)
    );

    logic        gnt_any;
    logic [31:0] win_addr;
    logic        addr_err;
    logic [31:0] rsp_data;
    logic        if_rsp;

    assign gnt_any  = if_gnt | mem_gnt;
    assign win_addr = mem_gnt ? mem_addr : if_addr;
    assign addr_err = gnt_any && rom_addr_bad(win_addr, ROM_BYTES_C);
    // A bad address is still granted (so the requester unblocks) but the
    // ROM is never enabled and the returned word is forced to zero.
    assign rom_ce   = (gnt_any && !addr_err) ? CHIP_ENABLE : CHIP_DISABLE;
    assign rom_addr = gnt_any ? win_addr : ZERO_WORD;
    assign rsp_data = addr_err ? ZERO_WORD : rom_inst;
    // A flushed fetch consumes its grant but produces no response.
    assign if_rsp   = if_gnt && !if_flush;

    logic        if_rvalid_q;
    logic        mem_rvalid_q;
    logic        rsp_err_q;
    logic [31:0] if_inst_q;
    logic [31:0] mem_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rvalid_q  <= 1'b0;
            mem_rvalid_q <= 1'b0;
            rsp_err_q    <= 1'b0;
            if_inst_q    <= ZERO_WORD;
            mem_rdata_q  <= ZERO_WORD;
        end else begin
            if_rvalid_q  <= if_rsp;
            mem_rvalid_q <= mem_gnt;
            rsp_err_q    <= addr_err && (mem_gnt || if_rsp);
            if (if_rsp) begin
                if_inst_q <= rsp_data;
            end
            if (mem_gnt) begin
                mem_rdata_q <= rsp_data;
            end
        end
    end

    assign if_rvalid  = if_rvalid_q;
    assign mem_rvalid = mem_rvalid_q;
    assign rsp_err    = rsp_err_q;
    assign if_inst    = if_inst_q;
    assign mem_rdata  = mem_rdata_q;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_arbiter
// Self-checking bench for inst_rom_arbiter. A behavioural ROM drives rom_inst
// from rom_ce/rom_addr; a reference model tracks wait times, last owner and
// the expected response of every cycle. Honours ROM_ARB_FAIR_EN if defined.
// -----------------------------------------------------------------------------
module tb_inst_rom_arbiter;
    import inst_rom_arbiter_pkg::*;

    localparam int          MAXW      = 4;
    localparam logic [31:0] ROM_BYTES = 32'(INST_MEM_NUM * 4);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0, mem_req = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0;
    logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid, rsp_err, rom_ce;
    logic [31:0] if_inst, mem_rdata, rom_addr, rom_inst;

    logic [31:0] rom_mem [0:INST_MEM_NUM-1];

    // Disabled ROM returns junk so a leaked rom_inst on an error is visible.
    assign rom_inst = rom_ce ? rom_mem[rom_addr[11:2]] : 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    inst_rom_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_inst(if_inst),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_err(rsp_err), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    int          m_if_wait, m_mem_wait;
    bit          m_last_mem;
    bit          e_if_rvalid, e_mem_rvalid, e_err;
    logic [31:0] e_if_inst, e_mem_rdata;
    // Observations of the most recent cycle's combinational outputs
    bit          o_if_gnt, o_mem_gnt;
    logic        o_rom_ce;

    task automatic model_reset();
        m_if_wait    = 0;
        m_mem_wait   = 0;
        m_last_mem   = 1'b1;
        e_if_rvalid  = 1'b0;
        e_mem_rvalid = 1'b0;
        e_err        = 1'b0;
        e_if_inst    = '0;
        e_mem_rdata  = '0;
    endtask

    task automatic apply_reset();
        if_req = 1'b0; mem_req = 1'b0; if_flush = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        rst = 1'b1;
    endtask

    // One clock of stimulus, starting and ending 1 time unit after posedge.
    task automatic run_cycle(input bit ir, input logic [31:0] ia, input bit fl,
                             input bit mr, input logic [31:0] ma);
        bit          ew_if, ew_mem, ew_any, bad;
        logic [31:0] wa, ed, e_addr;
        if_req = ir; if_addr = ia; if_flush = fl;
        mem_req = mr; mem_addr = ma;
        #3;
        ew_if = 1'b0; ew_mem = 1'b0;
        if (ir && mr) begin
            if (m_if_wait >= MAXW && m_mem_wait < MAXW) ew_if = 1'b1;
            else if (m_mem_wait >= MAXW && m_if_wait < MAXW) ew_mem = 1'b1;
`ifdef ROM_ARB_FAIR_EN
            else if (m_last_mem) ew_if = 1'b1;
            else ew_mem = 1'b1;
`else
            else ew_mem = 1'b1;
`endif
        end else begin
            ew_if = ir; ew_mem = mr;
        end
        ew_any = ew_if || ew_mem;
        wa     = ew_mem ? ma : ia;
        bad    = ew_any && ((wa[1:0] != 2'b00) || (wa >= ROM_BYTES));
        e_addr = ew_any ? wa : 32'h0;
        ed     = bad ? 32'h0 : rom_mem[wa[11:2]];

        o_if_gnt = if_gnt; o_mem_gnt = mem_gnt; o_rom_ce = rom_ce;
        checks++;
        if (if_gnt !== ew_if || mem_gnt !== ew_mem) begin
            errors++;
            $display("FAIL gnt cyc=%0d: if_gnt=%b mem_gnt=%b required %b %b",
                     cyc, if_gnt, mem_gnt, ew_if, ew_mem);
        end
        checks++;
        if (rom_ce !== (ew_any && !bad) || rom_addr !== e_addr) begin
            errors++;
            $display("FAIL rom_bus cyc=%0d: ce=%b addr=%h required ce=%b addr=%h",
                     cyc, rom_ce, rom_addr, ew_any && !bad, e_addr);
        end

        m_if_wait  = (ir && !ew_if)  ? ((m_if_wait  + 1 > MAXW) ? MAXW : m_if_wait  + 1) : 0;
        m_mem_wait = (mr && !ew_mem) ? ((m_mem_wait + 1 > MAXW) ? MAXW : m_mem_wait + 1) : 0;
        if (ew_if) m_last_mem = 1'b0;
        else if (ew_mem) m_last_mem = 1'b1;
        e_if_rvalid  = ew_if && !fl;
        e_mem_rvalid = ew_mem;
        e_err        = bad && (ew_mem || (ew_if && !fl));
        if (e_if_rvalid) e_if_inst = ed;
        if (ew_mem) e_mem_rdata = ed;

        @(posedge clk); #1;
        cyc++;
        checks++;
        if (if_rvalid !== e_if_rvalid || mem_rvalid !== e_mem_rvalid || rsp_err !== e_err) begin
            errors++;
            $display("FAIL rsp_flags cyc=%0d: if_rvalid=%b mem_rvalid=%b rsp_err=%b required %b %b %b",
                     cyc, if_rvalid, mem_rvalid, rsp_err, e_if_rvalid, e_mem_rvalid, e_err);
        end
        checks++;
        if (if_inst !== e_if_inst || mem_rdata !== e_mem_rdata) begin
            errors++;
            $display("FAIL rsp_data cyc=%0d: if_inst=%h mem_rdata=%h required %h %h",
                     cyc, if_inst, mem_rdata, e_if_inst, e_mem_rdata);
        end
        $display("cyc %0d req if=%b mem=%b flush=%b gnt if=%b mem=%b rsp if=%b mem=%b err=%b",
                 cyc, ir, mr, fl, o_if_gnt, o_mem_gnt, if_rvalid, mem_rvalid, rsp_err);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return {20'h0, 10'($urandom_range(0, INST_MEM_NUM - 1)), 2'($urandom_range(1, 3))};
        if (r == 1) return ROM_BYTES + 32'(4 * $urandom_range(0, 100));
        return {20'h0, 10'($urandom_range(0, INST_MEM_NUM - 1)), 2'b00};
    endfunction

    task automatic test_reset();
        if_req = 1'b1; if_addr = 32'h10; mem_req = 1'b0;
        #1;
        checks++;
        if (if_rvalid !== 1'b0 || mem_rvalid !== 1'b0 || rsp_err !== 1'b0 ||
            if_inst !== 32'h0 || mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: rv=%b/%b err=%b inst=%h rdata=%h required all zero",
                     if_rvalid, mem_rvalid, rsp_err, if_inst, mem_rdata);
        end
        checks++;
        if (if_gnt !== 1'b1 || mem_gnt !== 1'b0 || rom_ce !== 1'b1 || rom_addr !== 32'h10) begin
            errors++;
            $display("FAIL reset_comb: gnt=%b/%b ce=%b addr=%h required 1/0 1 00000010",
                     if_gnt, mem_gnt, rom_ce, rom_addr);
        end
        apply_reset();
    endtask

    task automatic test_single_fetch();
        apply_reset();
        rom_mem[2] = 32'h1234_5678;
        run_cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
        checks++;
        if (o_if_gnt !== 1'b1 || if_rvalid !== 1'b1 || if_inst !== 32'h1234_5678) begin
            errors++;
            $display("FAIL single_fetch: gnt=%b rvalid=%b inst=%h required 1 1 12345678",
                     o_if_gnt, if_rvalid, if_inst);
        end
        run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (if_rvalid !== 1'b0 || if_inst !== 32'h1234_5678) begin
            errors++;
            $display("FAIL fetch_hold: rvalid=%b inst=%h required 0 12345678", if_rvalid, if_inst);
        end
    endtask

    task automatic test_tie();
        bit exp_if;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
`ifdef ROM_ARB_FAIR_EN
            exp_if = (i % 2 == 0);
`else
            exp_if = (i % 5 == 4);
`endif
            run_cycle(1'b1, {20'h0, 10'($urandom_range(0, 1023)), 2'b00}, 1'b0,
                      1'b1, {20'h0, 10'($urandom_range(0, 1023)), 2'b00});
            checks++;
            if (o_if_gnt !== exp_if || o_mem_gnt !== !exp_if) begin
                errors++;
                $display("FAIL tie_seq[%0d]: if_gnt=%b mem_gnt=%b required %b %b",
                         i, o_if_gnt, o_mem_gnt, exp_if, !exp_if);
            end
        end
    endtask

    task automatic test_error();
        apply_reset();
        run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h6);
        checks++;
        if (o_mem_gnt !== 1'b1 || o_rom_ce !== 1'b0 || mem_rvalid !== 1'b1 ||
            rsp_err !== 1'b1 || mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL misaligned: gnt=%b ce=%b rvalid=%b err=%b data=%h required 1 0 1 1 0",
                     o_mem_gnt, o_rom_ce, mem_rvalid, rsp_err, mem_rdata);
        end
        run_cycle(1'b1, ROM_BYTES, 1'b0, 1'b0, 32'h0);
        checks++;
        if (if_rvalid !== 1'b1 || rsp_err !== 1'b1 || if_inst !== 32'h0) begin
            errors++;
            $display("FAIL out_of_range: rvalid=%b err=%b inst=%h required 1 1 0",
                     if_rvalid, rsp_err, if_inst);
        end
        run_cycle(1'b1, ROM_BYTES - 4, 1'b0, 1'b0, 32'h0);
        checks++;
        if (rsp_err !== 1'b0 || if_inst !== rom_mem[INST_MEM_NUM-1]) begin
            errors++;
            $display("FAIL last_word: err=%b inst=%h required 0 %h",
                     rsp_err, if_inst, rom_mem[INST_MEM_NUM-1]);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        run_cycle(1'b1, 32'h14, 1'b1, 1'b0, 32'h0);
        checks++;
        if (o_if_gnt !== 1'b1 || if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: gnt=%b rvalid=%b required 1 0", o_if_gnt, if_rvalid);
        end
        run_cycle(1'b1, 32'h18, 1'b0, 1'b0, 32'h0);
        checks++;
        if (if_rvalid !== 1'b1 || if_inst !== rom_mem[6]) begin
            errors++;
            $display("FAIL flush_next: rvalid=%b inst=%h required 1 %h", if_rvalid, if_inst, rom_mem[6]);
        end
        run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h20);
        checks++;
        if (mem_rvalid !== 1'b1 || mem_rdata !== rom_mem[8]) begin
            errors++;
            $display("FAIL flush_mem: rvalid=%b data=%h required 1 %h", mem_rvalid, mem_rdata, rom_mem[8]);
        end
    endtask

    task automatic test_random();
        bit          p_if, p_mem;
        logic [31:0] a_if, a_mem;
        apply_reset();
        p_if = 1'b0; p_mem = 1'b0; a_if = '0; a_mem = '0;
        for (int i = 0; i < 300; i++) begin
            if (!p_if) begin
                p_if = ($urandom_range(0, 2) != 0);
                a_if = rand_addr();
            end
            if (!p_mem) begin
                p_mem = ($urandom_range(0, 2) != 0);
                a_mem = rand_addr();
            end
            run_cycle(p_if, a_if, ($urandom_range(0, 4) == 0), p_mem, a_mem);
            if (o_if_gnt) p_if = 1'b0;
            if (o_mem_gnt) p_mem = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        if_req = 1'b0; mem_req = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_rvalid !== 1'b0 || if_rvalid !== 1'b0 || rsp_err !== 1'b0 ||
            mem_rdata !== 32'h0 || if_inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: rv=%b/%b err=%b rdata=%h inst=%h required all zero",
                     if_rvalid, mem_rvalid, rsp_err, mem_rdata, if_inst);
        end
        @(posedge clk); #1;
        model_reset();
        rst = 1'b1;
        run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (mem_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rv=%b/%b required 0/0", if_rvalid, mem_rvalid);
        end
    endtask

    initial begin
        for (int i = 0; i < INST_MEM_NUM; i++) rom_mem[i] = $urandom;
        model_reset();
        test_reset();
        test_single_fetch();
        test_tie();
        test_error();
        test_flush();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
